loop_recorder: RTL and testbench

//  Multi-slot audio sample recorder/player. It captures a signed PCM stream into on-chip RAM.
//  Up to NUM_SLOTS independent clips, each one up to DEPTH samples long, are stored at once.

---
 rtl/loop_recorder_pkg.sv | 28 ++
 rtl/loop_recorder_if.sv | 32 +++
 rtl/loop_recorder_bram.sv | 21 ++
 rtl/loop_recorder.sv | 199 +++++++++++++++++++
 tb/tb_loop_recorder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/loop_recorder_pkg.sv
// loop_recorder_pkg: shared FSM state type and saturating add.
// sat_add clamps a+b to the signed range of a w-bit sample.
package loop_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY,
    OVERDUB
  } state_t;

  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int w
  );
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/loop_recorder_if.sv
// loop_recorder_if: control, sample stream and status bundle.
// master drives record/play/loop/slot/audio_in; slave returns audio/status.
interface loop_recorder_if #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int SLOT_W = 2
);
  logic                    record_in;
  logic                    play_in;
  logic                    loop_in;
  logic [SLOT_W-1:0]       slot_in;
  logic                    audio_valid_in;
  logic [SAMPLE_WIDTH-1:0] audio_in;
  logic [SAMPLE_WIDTH-1:0] audio_out;
  logic                    audio_valid_out;
  logic                    busy_out;
  logic                    full_out;
  logic                    done_out;

  modport master (
    output record_in, play_in, loop_in, slot_in,
    output audio_valid_in, audio_in,
    input  audio_out, audio_valid_out,
    input  busy_out, full_out, done_out
  );

  modport slave (
    input  record_in, play_in, loop_in, slot_in,
    input  audio_valid_in, audio_in,
    output audio_out, audio_valid_out,
    output busy_out, full_out, done_out
  );
endinterface

// File: rtl/loop_recorder_bram.sv
// recorder_bram: simple dual-port sample RAM, one write, one read port.
// Ports: clk_in, we/waddr/wdata write; re/raddr read, rdata 1 cycle later.
module recorder_bram #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int AW = 16
) (
  input  logic                    clk_in,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [SAMPLE_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [SAMPLE_WIDTH-1:0] rdata
);
  logic [SAMPLE_WIDTH-1:0] mem [1 << AW];

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/loop_recorder.sv
// loop_recorder: multi-slot PCM recorder/player, one-shot or looped clips.
// Ports: clk_in, rst_in (async high), bus (slave). Overdub: LOOP_RECORDER_OVERDUB_EN.
module loop_recorder
  import loop_recorder_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH = 16384,
  parameter int NUM_SLOTS = 4
) (
  input logic            clk_in,
  input logic            rst_in,
  loop_recorder_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SLOT_W =
    (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int RAM_AW = SLOT_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_LEN =
    (ADDR_W + 1)'(DEPTH);

  state_t                  state;
  logic [ADDR_W-1:0]       addr;
  logic [SLOT_W-1:0]       cur_slot;
  logic [ADDR_W:0]         len [NUM_SLOTS];
  logic                    rec_block;
  logic                    p1_vld;
  logic                    p1_last;
  logic [ADDR_W:0]         cur_len;
  logic                    at_end;
  logic                    rec_abort;
  logic                    rd_go;
  logic                    we;
  logic [RAM_AW-1:0]       waddr;
  logic [SAMPLE_WIDTH-1:0] wdata;
  logic [SAMPLE_WIDTH-1:0] rd_data;

  assign cur_len = len[cur_slot];
  assign at_end =
    {1'b0, addr} == cur_len - (ADDR_W + 1)'(1);

`ifdef LOOP_RECORDER_OVERDUB_EN
  logic                    rec_q;
  logic                    p1_dub;
  logic [RAM_AW-1:0]       p1_addr;
  logic [SAMPLE_WIDTH-1:0] p1_in;
  logic                    wb_en;
  logic [RAM_AW-1:0]       wb_addr;
  logic [SAMPLE_WIDTH-1:0] wb_data;
  // record_in in PLAY enters OVERDUB rather than aborting
  assign rec_abort = 1'b0;
`else
  assign rec_abort = (state == PLAY) && bus.record_in;
`endif

  assign rd_go = (state == PLAY || state == OVERDUB)
    && bus.play_in && !rec_abort
    && (cur_len != '0) && bus.audio_valid_in;

  always_comb begin
    we    = (state == RECORD) && bus.record_in
            && bus.audio_valid_in;
    waddr = {cur_slot, addr};
    wdata = bus.audio_in;
`ifdef LOOP_RECORDER_OVERDUB_EN
    if (wb_en) begin
      we    = 1'b1;
      waddr = wb_addr;
      wdata = wb_data;
    end
`endif
  end

  recorder_bram #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .AW(RAM_AW)
  ) u_bram (
    .clk_in(clk_in),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(rd_go),
    .raddr({cur_slot, addr}),
    .rdata(rd_data)
  );

  assign bus.busy_out = (state != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state               <= IDLE;
      addr                <= '0;
      cur_slot            <= '0;
      rec_block           <= 1'b0;
      p1_vld              <= 1'b0;
      p1_last             <= 1'b0;
      bus.audio_out       <= '0;
      bus.audio_valid_out <= 1'b0;
      bus.full_out        <= 1'b0;
      bus.done_out        <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++)
        len[i] <= '0;
`ifdef LOOP_RECORDER_OVERDUB_EN
      rec_q   <= 1'b0;
      p1_dub  <= 1'b0;
      p1_addr <= '0;
      p1_in   <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
`endif
    end else begin
      // read issue -> RAM -> output register
      p1_vld              <= rd_go;
      p1_last             <= rd_go && at_end
                             && !bus.loop_in;
      bus.audio_valid_out <= p1_vld;
      bus.done_out        <= p1_last;
      bus.full_out        <= 1'b0;
      if (p1_vld) bus.audio_out <= rd_data;
      if (!bus.record_in) rec_block <= 1'b0;
`ifdef LOOP_RECORDER_OVERDUB_EN
      rec_q   <= bus.record_in;
      p1_dub  <= rd_go && (state == OVERDUB)
                 && bus.record_in;
      p1_addr <= {cur_slot, addr};
      p1_in   <= bus.audio_in;
      wb_en   <= p1_dub;
      wb_addr <= p1_addr;
      wb_data <= SAMPLE_WIDTH'(sat_add(
        32'(signed'(rd_data)),
        32'(signed'(p1_in)), SAMPLE_WIDTH));
`endif
      unique case (state)
        IDLE: begin
          if (bus.record_in) begin
            // after a full stop, wait for record_in to re-arm
            if (!rec_block) begin
              state    <= RECORD;
              cur_slot <= bus.slot_in;
              addr     <= '0;
            end
          end else if (bus.play_in) begin
            state    <= PLAY;
            cur_slot <= bus.slot_in;
            addr     <= '0;
          end
        end
        RECORD: begin
          if (!bus.record_in) begin
            len[cur_slot] <= {1'b0, addr};
            state         <= IDLE;
          end else if (bus.audio_valid_in) begin
            if (addr == LAST_A) begin
              len[cur_slot] <= FULL_LEN;
              bus.full_out  <= 1'b1;
              rec_block     <= 1'b1;
              state         <= IDLE;
              addr          <= '0;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        PLAY, OVERDUB: begin
          if (rec_abort) begin
            state    <= RECORD;
            cur_slot <= bus.slot_in;
            addr     <= '0;
          end else if (!bus.play_in) begin
            state <= IDLE;
          end else if (cur_len == '0) begin
            bus.done_out <= 1'b1;
            state        <= IDLE;
          end else begin
`ifdef LOOP_RECORDER_OVERDUB_EN
            if (state == PLAY && bus.record_in
                && !rec_q)
              state <= OVERDUB;
            else if (state == OVERDUB
                     && !bus.record_in)
              state <= PLAY;
`endif
            if (bus.audio_valid_in) begin
              if (at_end) begin
                if (bus.loop_in) addr <= '0;
                else state <= IDLE;
              end else begin
                addr <= addr + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loop_recorder.sv
// tb_loop_recorder: directed record/play scenarios with a sample scoreboard.
// Expected samples are queued at stimulus time and popped per audio_valid_out.
module tb_loop_recorder;
  localparam int SW = 8;
  localparam int DEPTH = 512;
  localparam int NS = 4;
  localparam int SLW = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  loop_recorder_if #(
    .SAMPLE_WIDTH(SW),
    .SLOT_W(SLW)
  ) bus ();

  loop_recorder #(
    .SAMPLE_WIDTH(SW),
    .DEPTH(DEPTH),
    .NUM_SLOTS(NS)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] mon_e;
  bit chk = 1'b0;
  int done_cnt = 0;
  int full_cnt = 0;
  int vout_cnt = 0;
  logic [SW-1:0] done_val = '0;
  logic done_vld = 1'b0;
  int d0;
  int v0;
  logic [SW-1:0] dub_exp;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic strobe(logic [SW-1:0] d);
    @(posedge clk_in);
    #1;
    bus.audio_in = d;
    bus.audio_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    bus.audio_valid_in = 1'b0;
  endtask

  task automatic rec(int slot, int n, logic [SW-1:0] v,
                     bit incr);
    bus.slot_in = SLW'(slot);
    bus.record_in = 1'b1;
    tick(1);
    for (int i = 0; i < n; i++)
      strobe(incr ? SW'(i) : v);
    bus.record_in = 1'b0;
    tick(2);
  endtask

  task automatic play(int slot, int n, bit lp);
    bus.slot_in = SLW'(slot);
    bus.loop_in = lp;
    bus.play_in = 1'b1;
    tick(1);
    for (int i = 0; i < n; i++)
      strobe(8'h00);
    bus.play_in = 1'b0;
    tick(5);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.audio_valid_out) begin
        vout_cnt++;
        if (chk) begin
          total++;
          assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL extra_sample observed=%0h expected=none",
                   bus.audio_out);
          end
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            assert (bus.audio_out === mon_e) else begin
              bad++;
              $error("FAIL sample observed=%0h expected=%0h",
                     bus.audio_out, mon_e);
            end
          end
        end
      end
      if (bus.done_out) begin
        done_cnt++;
        done_val = bus.audio_out;
        done_vld = bus.audio_valid_out;
      end
      if (bus.full_out) full_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.record_in = 1'b0;
    bus.play_in = 1'b0;
    bus.loop_in = 1'b0;
    bus.slot_in = '0;
    bus.audio_valid_in = 1'b0;
    bus.audio_in = '0;

    // reset state
    tick(3);
    @(negedge clk_in);
    check("rst_audio_out", 32'(bus.audio_out), 0);
    check("rst_valid_out", 32'(bus.audio_valid_out), 0);
    check("rst_busy", 32'(bus.busy_out), 0);
    check("rst_full", 32'(bus.full_out), 0);
    check("rst_done", 32'(bus.done_out), 0);
    rst_in = 1'b0;
    tick(2);
    chk = 1'b1;

    // 1: record 0..99 in slot 0, one-shot play
    rec(0, 100, '0, 1'b1);
    check("rec_idle_busy", 32'(bus.busy_out), 0);
    for (int i = 0; i < 100; i++) exp_q.push_back(SW'(i));
    play(0, 100, 1'b0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_vld", 32'(done_vld), 1);
    check("t1_done_val", 32'(done_val), 99);
    check("t1_drained", exp_q.size(), 0);
    check("t1_busy", 32'(bus.busy_out), 0);

    // 2: looped play, 250 strobes
    for (int i = 0; i < 250; i++)
      exp_q.push_back(SW'(i % 100));
    play(0, 250, 1'b1);
    check("t2_no_done", done_cnt, 1);
    check("t2_drained", exp_q.size(), 0);

    // 3: record past DEPTH into slot 3
    rec(3, DEPTH + 5, '0, 1'b1);
    check("t3_full_cnt", full_cnt, 1);
    check("t3_busy", 32'(bus.busy_out), 0);
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back(SW'(i));
    play(3, DEPTH, 1'b0);
    check("t3_done_cnt", done_cnt, 2);
    check("t3_done_val", 32'(done_val), (DEPTH - 1) & 8'hFF);
    check("t3_drained", exp_q.size(), 0);

    // 4: independent slots
    rec(1, 10, 8'hA5, 1'b0);
    rec(2, 20, 8'h3C, 1'b0);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'hA5);
    play(1, 10, 1'b0);
    check("t4_s1_done_val", 32'(done_val), 32'hA5);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h3C);
    play(2, 20, 1'b0);
    check("t4_s2_done_val", 32'(done_val), 32'h3C);
    for (int i = 0; i < 100; i++) exp_q.push_back(SW'(i));
    play(0, 100, 1'b0);
    check("t4_s0_done_val", 32'(done_val), 99);
    check("t4_done_cnt", done_cnt, 5);
    check("t4_drained", exp_q.size(), 0);

    // 5: reset in the middle of play
    chk = 1'b0;
    bus.slot_in = '0;
    bus.loop_in = 1'b1;
    bus.play_in = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) strobe(8'h00);
    bus.play_in = 1'b0;
    rst_in = 1'b1;
    tick(1);
    @(negedge clk_in);
    check("t5_audio_out", 32'(bus.audio_out), 0);
    check("t5_valid_out", 32'(bus.audio_valid_out), 0);
    check("t5_busy", 32'(bus.busy_out), 0);
    check("t5_done", 32'(bus.done_out), 0);
    rst_in = 1'b0;
    tick(2);
    chk = 1'b1;
    d0 = done_cnt;
    v0 = vout_cnt;
    bus.loop_in = 1'b0;
    bus.play_in = 1'b1;
    tick(2);
    bus.play_in = 1'b0;
    tick(4);
    check("t5_empty_done", done_cnt, d0 + 1);
    check("t5_no_samples", vout_cnt, v0);
    check("t5_busy_after", 32'(bus.busy_out), 0);

    // 6: overdub (or re-record) on slot 2
    rec(2, 10, 8'd100, 1'b0);
    chk = 1'b0;
    bus.slot_in = 2'd2;
    bus.loop_in = 1'b1;
    bus.play_in = 1'b1;
    tick(2);
    bus.record_in = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) strobe(8'd50);
    bus.record_in = 1'b0;
    tick(1);
    bus.play_in = 1'b0;
    tick(6);
    exp_q.delete();
    chk = 1'b1;
`ifdef LOOP_RECORDER_OVERDUB_EN
    dub_exp = 8'd127;
`else
    dub_exp = 8'd50;
`endif
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) exp_q.push_back(dub_exp);
    play(2, 10, 1'b0);
    check("t6_done_cnt", done_cnt, d0 + 1);
    check("t6_done_val", 32'(done_val), 32'(dub_exp));
    check("t6_drained", exp_q.size(), 0);
    check("t6_busy", 32'(bus.busy_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
